// File: rtl/fp_op_sequencer_pkg.sv
// Shared types and constants for the bfloat16 FPU operator sequencer.
//  - fp_alu_op_e     : FPU operation code (MADD is sequenced, the FPU itself lacks it)
//  - fp_seq_state_e  : sequencer FSM states
//  - FP_SEQ_MAX_LAT  : largest supported FPU_LAT
//  - fp_seq_first_op : operator issued in the first FPU pass of an operation
package fp_op_sequencer_pkg;

  localparam int unsigned FP_DATA_W      = 32;
  localparam int unsigned FP_MODE_W      = 2;
  localparam int unsigned FP_SEQ_MAX_LAT = 7;
  localparam int unsigned FP_SEQ_CNT_W   = 3;

  typedef enum logic [3:0] {
    FP_ALU_ADD    = 4'd0,
    FP_ALU_SUB    = 4'd1,
    FP_ALU_MUL    = 4'd2,
    FP_ALU_MADD   = 4'd3,
    FP_ALU_MINMAX = 4'd4,
    FP_ALU_SGNJ   = 4'd5,
    FP_ALU_CMP    = 4'd6,
    FP_ALU_CVT    = 4'd7
  } fp_alu_op_e;

  typedef enum logic [1:0] {
    FPS_IDLE,
    FPS_EXEC,
    FPS_MADD_ADD,
    FPS_RESP
  } fp_seq_state_e;

  // MADD starts as a multiply; every other op goes to the FPU unchanged.
  function automatic fp_alu_op_e fp_seq_first_op(input fp_alu_op_e op);
    return (op == FP_ALU_MADD) ? FP_ALU_MUL : op;
  endfunction

endpackage

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: initiator side of the bfloat16 FPU operator/operand interface.
// Registers one request from ID, drives it into a combinational (or FPU_LAT-deep)
// FPU, samples the result and returns it to writeback. MADD runs as MUL then ADD
// (two roundings).
//
// Parameters:
//   FPU_LAT  cycles to wait before sampling fpu_result_i (0..7, clamped)
// Configuration macro:
//   FP_SEQ_B2B_EN  when defined, a new request is accepted in the same cycle the
//                  response handshakes (zero-bubble back-to-back operation)
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   req_valid_i/req_ready_o           request handshake from ID
//   req_op_i, req_mode_i              operation and convert mode
//   req_a_i, req_b_i, req_c_i         operands (bf16 in [31:16]); c = MADD addend
//   fpu_operator_o, fpu_operand_a_o,
//   fpu_operand_b_o, fpu_mode_o       registered drive into the FPU
//   fpu_result_i                      FPU result
//   rsp_valid_o/rsp_ready_i           response handshake to writeback
//   rsp_result_o                      response data
//   busy_o                            sequencer not idle
module fp_op_sequencer
  import fp_op_sequencer_pkg::*;
#(
  parameter int unsigned FPU_LAT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  fp_alu_op_e           req_op_i,
  input  logic [FP_MODE_W-1:0] req_mode_i,
  input  logic [FP_DATA_W-1:0] req_a_i,
  input  logic [FP_DATA_W-1:0] req_b_i,
  input  logic [FP_DATA_W-1:0] req_c_i,
  output fp_alu_op_e           fpu_operator_o,
  output logic [FP_DATA_W-1:0] fpu_operand_a_o,
  output logic [FP_DATA_W-1:0] fpu_operand_b_o,
  output logic [FP_MODE_W-1:0] fpu_mode_o,
  input  logic [FP_DATA_W-1:0] fpu_result_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [FP_DATA_W-1:0] rsp_result_o,
  output logic                 busy_o
);

  // Out-of-range latencies saturate at the deepest supported FPU.
  localparam int unsigned LAT_C = (FPU_LAT > FP_SEQ_MAX_LAT) ? FP_SEQ_MAX_LAT : FPU_LAT;
  localparam logic [FP_SEQ_CNT_W-1:0] LAT_RELOAD = FP_SEQ_CNT_W'(LAT_C);
  localparam logic [FP_SEQ_CNT_W-1:0] CNT_ONE    = FP_SEQ_CNT_W'(1);

  fp_seq_state_e           state_q, state_d;
  logic [FP_SEQ_CNT_W-1:0] cnt_q;
  fp_alu_op_e              op_q;
  logic [FP_DATA_W-1:0]    c_q;
  fp_alu_op_e              fpu_op_q;
  logic [FP_DATA_W-1:0]    fpu_a_q;
  logic [FP_DATA_W-1:0]    fpu_b_q;
  logic [FP_MODE_W-1:0]    fpu_mode_q;
  logic [FP_DATA_W-1:0]    res_q;

  logic cnt_last_c;
  logic accept_c;
  logic exec_busy_c;
  logic madd_split_c;

  // The FPU has had its full latency on the current operands.
  assign cnt_last_c = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FPS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FPS_IDLE: begin
        if (req_valid_i) state_d = FPS_EXEC;
      end
      FPS_EXEC: begin
        if (cnt_last_c) state_d = (op_q == FP_ALU_MADD) ? FPS_MADD_ADD : FPS_RESP;
      end
      FPS_MADD_ADD: begin
        if (cnt_last_c) state_d = FPS_RESP;
      end
      FPS_RESP: begin
        if (rsp_ready_i) begin
`ifdef FP_SEQ_B2B_EN
          state_d = req_valid_i ? FPS_EXEC : FPS_IDLE;
`else
          state_d = FPS_IDLE;
`endif
        end
      end
      default: state_d = FPS_IDLE;
    endcase
  end

  // Output decode and datapath strobes.
  always_comb begin
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    busy_o       = 1'b1;
    exec_busy_c  = 1'b0;
    madd_split_c = 1'b0;
    case (state_q)
      FPS_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      FPS_EXEC: begin
        exec_busy_c  = 1'b1;
        madd_split_c = (op_q == FP_ALU_MADD);
      end
      FPS_MADD_ADD: begin
        exec_busy_c = 1'b1;
      end
      FPS_RESP: begin
        rsp_valid_o = 1'b1;
`ifdef FP_SEQ_B2B_EN
        // Ready follows the response side so a retiring response frees the slot.
        req_ready_o = rsp_ready_i;
`endif
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
    accept_c = req_valid_i && req_ready_o;
  end

  // Request, FPU drive and result registers; the FPU only ever sees registered values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= FP_ALU_ADD;
      c_q        <= '0;
      fpu_op_q   <= FP_ALU_ADD;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_mode_q <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
    end else if (accept_c) begin
      op_q       <= req_op_i;
      c_q        <= req_c_i;
      fpu_op_q   <= fp_seq_first_op(req_op_i);
      fpu_a_q    <= req_a_i;
      fpu_b_q    <= req_b_i;
      fpu_mode_q <= req_mode_i;
      cnt_q      <= LAT_RELOAD;
    end else if (exec_busy_c) begin
      if (!cnt_last_c) begin
        cnt_q <= cnt_q - CNT_ONE;
      end else if (madd_split_c) begin
        // Product feeds the second pass as operand a, addend as operand b.
        fpu_op_q <= FP_ALU_ADD;
        fpu_a_q  <= fpu_result_i;
        fpu_b_q  <= c_q;
        cnt_q    <= LAT_RELOAD;
      end else begin
        res_q <= fpu_result_i;
      end
    end
  end

  assign fpu_operator_o  = fpu_op_q;
  assign fpu_operand_a_o = fpu_a_q;
  assign fpu_operand_b_o = fpu_b_q;
  assign fpu_mode_o      = fpu_mode_q;
  assign rsp_result_o    = res_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Scoreboard bench for fp_op_sequencer. A stub FPU with FPU_LAT-cycle validity
// drives fpu_result_i; expected results come from a direct arithmetic model.
module tb_fp_op_sequencer;
  import fp_op_sequencer_pkg::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned STEP = LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  fp_alu_op_e  req_op_i;
  logic [1:0]  req_mode_i;
  logic [31:0] req_a_i, req_b_i, req_c_i;
  fp_alu_op_e  fpu_operator_o;
  logic [31:0] fpu_operand_a_o, fpu_operand_b_o;
  logic [1:0]  fpu_mode_o;
  logic [31:0] fpu_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rdy_mode = 1;  // 0 random, 1 always ready, 2 always stalled

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];

  fp_op_sequencer #(.FPU_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_mode_i(req_mode_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
    .fpu_operator_o(fpu_operator_o), .fpu_operand_a_o(fpu_operand_a_o),
    .fpu_operand_b_o(fpu_operand_b_o), .fpu_mode_o(fpu_mode_o),
    .fpu_result_i(fpu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub FPU operations on raw words; ops it does not implement (incl. MADD) return 0.
  function automatic logic [31:0] stub_fpu(fp_alu_op_e op, logic [31:0] a, logic [31:0] b, logic [1:0] m);
    case (op)
      FP_ALU_ADD: return a + b;
      FP_ALU_SUB: return a - b;
      FP_ALU_MUL: return a * b;
      FP_ALU_CVT: return a ^ {30'd0, m};
      default:    return 32'd0;
    endcase
  endfunction

  // Reference: what the sequenced operation should return to writeback.
  function automatic logic [31:0] ref_result(fp_alu_op_e op, logic [31:0] a, logic [31:0] b,
                                             logic [31:0] c, logic [1:0] m);
    logic [31:0] prod;
    prod = a * b;
    case (op)
      FP_ALU_ADD:  return a + b;
      FP_ALU_SUB:  return a - b;
      FP_ALU_MUL:  return prod;
      FP_ALU_MADD: return prod + c;
      FP_ALU_CVT:  return a ^ {30'd0, m};
      default:     return 32'd0;
    endcase
  endfunction

  // Stub result is only valid once operands have been stable for LAT full cycles.
  logic [69:0] fpu_key;
  logic [69:0] last_key = '0;
  int          stable = 0;
  int          age;
  always_comb begin
    fpu_key = {fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o};
    age = (fpu_key == last_key) ? stable + 1 : 0;
    fpu_result_i = (age >= int'(LAT)) ? stub_fpu(fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o)
                                      : 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    last_key <= fpu_key;
    stable   <= (age > 100) ? 100 : age;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready_i = ($urandom_range(0, 3) != 0);
      1:       rsp_ready_i = 1'b1;
      default: rsp_ready_i = 1'b0;
    endcase
  end

  // Monitor: compares every response cycle against the head of the scoreboard.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid_o) begin
`ifdef FP_SEQ_B2B_EN
        exp_rdy = rsp_ready_i;
`else
        exp_rdy = 1'b0;
`endif
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got result %h with no request outstanding", rsp_result_o);
        end else begin
          if (!prev_valid) chk("latency", cyc, exp_cyc_q[0]);
          chk("result", rsp_result_o, exp_res_q[0]);
          chk("busy_in_resp", 32'(busy_o), 32'd1);
          chk("req_ready_in_resp", 32'(req_ready_o), 32'(exp_rdy));
          if (rsp_ready_i) begin
            void'(exp_res_q.pop_front());
            void'(exp_cyc_q.pop_front());
          end
        end
      end
      prev_valid = rsp_valid_o && !rsp_ready_i;
    end
  end

  // Issue one request; returns the cycle count after the accepting edge.
  task automatic send(input fp_alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [1:0] m, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    req_valid_i = 1'b1;
    req_op_i = op; req_a_i = a; req_b_i = b; req_c_i = c; req_mode_i = m;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        done = 1'b1;
        acc = cyc + 1;
        exp_res_q.push_back(ref_result(op, a, b, c, m));
        exp_cyc_q.push_back(acc + ((op == FP_ALU_MADD) ? 2 : 1) * int'(STEP));
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got no accept want accept within 300 cycles");
    end
    @(posedge clk);
    #1;
    // Junk on the idle request bus must not reach the FPU.
    req_valid_i = 1'b0;
    req_op_i = fp_alu_op_e'(4'($urandom_range(0, 15)));
    req_a_i = $urandom; req_b_i = $urandom; req_c_i = $urandom;
    req_mode_i = 2'($urandom_range(0, 3));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (exp_res_q.size() == 0 && !busy_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses pending want 0", exp_res_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result_o, 32'd0);
    chk({tag, "_fpu_op"}, 32'(fpu_operator_o), 32'(FP_ALU_ADD));
    chk({tag, "_fpu_a"}, fpu_operand_a_o, 32'd0);
    chk({tag, "_fpu_b"}, fpu_operand_b_o, 32'd0);
  endtask

  function automatic fp_alu_op_e rand_op();
    return fp_alu_op_e'(4'($urandom_range(0, 11)));  // 8..11 are unknown ops
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first_acc, last_acc;
    rst = 1'b1;
    req_valid_i = 1'b0;
    req_op_i = FP_ALU_ADD; req_a_i = '0; req_b_i = '0; req_c_i = '0; req_mode_i = '0;
    rsp_ready_i = 1'b0;
    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operations.
    rdy_mode = 1;
    send(FP_ALU_ADD,  32'h3F80_0000, 32'h4000_0000, 32'h0, 2'd0, acc);
    send(FP_ALU_SUB,  32'h4040_0000, 32'h3F80_0000, 32'h0, 2'd0, acc);
    send(FP_ALU_MADD, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 2'd0, acc);
    send(FP_ALU_MADD, 32'h0001_0003, 32'h0000_0005, 32'h1234_0000, 2'd1, acc);
    send(FP_ALU_CVT,  32'hABCD_0000, 32'h0, 32'h0, 2'd2, acc);
    send(FP_ALU_MINMAX, 32'h1111_1111, 32'h2222_2222, 32'h0, 2'd0, acc);
    send(fp_alu_op_e'(4'hC), 32'h5555_0000, 32'h6666_0000, 32'h0, 2'd3, acc);
    drain();

    // Backpressure: response must hold for several stalled cycles, then retire.
    rdy_mode = 2;
    send(FP_ALU_MUL, 32'h0000_0007, 32'h0000_0009, 32'h0, 2'd0, acc);
    repeat (STEP + 5) @(posedge clk);
    #1;
    chk("bp_valid_held", 32'(rsp_valid_o), 32'd1);
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_idle_after", 32'(busy_o), 32'd0);
    chk("bp_ready_after", 32'(req_ready_o), 32'd1);

    // Randomized traffic with random backpressure and gaps.
    rdy_mode = 0;
    for (int n = 0; n < 60; n++) begin
      send(rand_op(), $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 1;
    drain();

    // Streaming ADDs with the response side always ready.
    first_acc = 0;
    last_acc = 0;
    for (int n = 0; n < 8; n++) begin
      send(FP_ALU_ADD, $urandom, $urandom, 32'h0, 2'd0, acc);
      if (n == 0) first_acc = acc;
      last_acc = acc;
    end
`ifdef FP_SEQ_B2B_EN
    chk("stream_spacing", 32'(last_acc - first_acc), 32'(7 * (STEP + 1)));
`else
    chk("stream_spacing", 32'(last_acc - first_acc), 32'(7 * (STEP + 2)));
`endif
    drain();

    // Reset in the middle of the MADD add pass drops the operation.
    rdy_mode = 2;
    send(FP_ALU_MADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0005, 2'd0, acc);
    repeat (STEP) @(posedge clk);
    #1;
    chk("madd_add_busy", 32'(busy_o), 32'd1);
    chk("madd_add_operator", 32'(fpu_operator_o), 32'(FP_ALU_ADD));
    chk("madd_add_operand_a", fpu_operand_a_o, 32'd12);
    chk("madd_add_operand_b", fpu_operand_b_o, 32'd5);
    rst = 1'b1;
    #2;
    chk_reset_state("midreset");
    exp_res_q.delete();
    exp_cyc_q.delete();
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    repeat (3 * STEP + 4) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
